// File: rtl/axi_req_arbiter_pkg.sv
// Shared types and width helpers for the cache-side AXI request arbiter.
// Package name is kept generic because the cache subsystem reuses it.
package axi_cache_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 64;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_ISSUE     = 2'd1,
    ARB_WAIT_RESP = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                  is_write;
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
  } req_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_req_arbiter_rr.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping modulo N.
// N need not be a power of two, so wrap is an explicit compare-and-subtract.
module rr_arbiter
  import axi_cache_pkg::*;
#(
  parameter  int N  = 3,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  logic [IW:0]   cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    cand_idx  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      cand_idx = cand[IW-1:0];
      if (!any && req[cand_idx]) begin
        any             = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/axi_req_arbiter.sv
// Round-robin arbiter sharing the single-outstanding AXI driver port between
// cache requesters; routes each completion back to its owner.
module axi_req_arbiter
  import axi_cache_pkg::*;
#(
  parameter  int NUM_REQ        = 3,
  parameter  int ADDR_WIDTH     = AXI_ADDR_W,
  parameter  int DATA_WIDTH     = AXI_DATA_W,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int STRB_WIDTH     = DATA_WIDTH / 8,
  localparam int IDX_W          = idx_width(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_is_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ*STRB_WIDTH-1:0]    req_wstrb,
  output logic [NUM_REQ-1:0]               resp_valid,
  output logic [DATA_WIDTH-1:0]            resp_data,
  output logic                             drv_req_valid,
  input  logic                             drv_req_ready,
  output logic                             drv_req_is_write,
  output logic [ADDR_WIDTH-1:0]            drv_req_addr,
  output logic [DATA_WIDTH-1:0]            drv_req_wdata,
  output logic [STRB_WIDTH-1:0]            drv_req_wstrb,
  input  logic                             drv_resp_valid,
  input  logic [DATA_WIDTH-1:0]            drv_resp_data,
  output logic                             busy,
  output logic [IDX_W-1:0]                 grant_id,
  output logic                             timeout,
  output logic                             spurious_resp
);

  // Handshakes: a transfer happens on the rising edge where valid && ready;
  // valid never depends on ready, and ready is only offered in ARB_IDLE.

  localparam int               TMO_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
  localparam bit               TMO_EN    = (TIMEOUT_CYCLES != 0);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [NUM_REQ-1:0] win_grant;
  logic [IDX_W-1:0]  win_idx;
  logic              win_any;
  logic [TMO_W-1:0]  tmo_cnt_q;
  logic              accept, resp_done, in_flight;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (win_grant),
    .grant_idx (win_idx),
    .any       (win_any)
  );

  assign accept    = (state_q == ARB_IDLE) && win_any;
  assign resp_done = (state_q == ARB_WAIT_RESP) && drv_resp_valid;
  assign in_flight = (state_q != ARB_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:      if (win_any)        state_d = ARB_ISSUE;
      ARB_ISSUE:     if (drv_req_ready)  state_d = ARB_WAIT_RESP;
      ARB_WAIT_RESP: if (drv_resp_valid) state_d = ARB_IDLE;
      default:                           state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (state_q == ARB_IDLE) ? win_grant : '0;
    drv_req_valid = (state_q == ARB_ISSUE);
    busy          = in_flight;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drv_req_is_write <= 1'b0;
      drv_req_addr     <= '0;
      drv_req_wdata    <= '0;
      drv_req_wstrb    <= '0;
      grant_id         <= '0;
      rr_ptr_q         <= '0;
      resp_valid       <= '0;
      resp_data        <= '0;
    end else begin
      resp_valid <= '0;
      if (accept) begin
        drv_req_is_write <= req_is_write[win_idx];
        drv_req_addr     <= req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
        drv_req_wdata    <= req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
        drv_req_wstrb    <= req_wstrb[win_idx*STRB_WIDTH +: STRB_WIDTH];
        grant_id         <= win_idx;
      end
      if (resp_done) begin
        resp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
        resp_data  <= drv_req_is_write ? '0 : drv_resp_data;
        rr_ptr_q   <= (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + IDX_W'(1);
      end
    end
  end

  // Counter parks at the limit; with the timeout disabled the limit is 0 so it never moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q     <= '0;
      timeout       <= 1'b0;
      spurious_resp <= 1'b0;
    end else begin
      if (accept)                                 tmo_cnt_q <= '0;
      else if (in_flight && tmo_cnt_q != TMO_LIMIT) tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
      if (TMO_EN && tmo_cnt_q == TMO_LIMIT)       timeout   <= 1'b1;
      if (drv_resp_valid && state_q != ARB_WAIT_RESP) spurious_resp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Directed bench for axi_req_arbiter: three requesters, 64-bit data, timeout of 8 cycles.
module tb_axi_req_arbiter;

  localparam int NR = 3;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NR-1:0]     req_valid, req_ready, req_is_write, resp_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR*SW-1:0]  req_wstrb;
  logic [DW-1:0]     resp_data, drv_req_wdata, drv_resp_data;
  logic              drv_req_valid, drv_req_ready, drv_req_is_write;
  logic [AW-1:0]     drv_req_addr;
  logic [SW-1:0]     drv_req_wstrb;
  logic              drv_resp_valid, busy, timeout, spurious_resp;
  logic [1:0]        grant_id;

  int vectors = 0;
  int miscompares = 0;

  axi_req_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_write(req_is_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .drv_req_valid(drv_req_valid), .drv_req_ready(drv_req_ready),
    .drv_req_is_write(drv_req_is_write), .drv_req_addr(drv_req_addr),
    .drv_req_wdata(drv_req_wdata), .drv_req_wstrb(drv_req_wstrb),
    .drv_resp_valid(drv_resp_valid), .drv_resp_data(drv_resp_data),
    .busy(busy), .grant_id(grant_id), .timeout(timeout), .spurious_resp(spurious_resp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid      = '0;
    req_is_write   = '0;
    req_addr       = '0;
    req_wdata      = '0;
    req_wstrb      = '0;
    drv_req_ready  = 1'b0;
    drv_resp_valid = 1'b0;
    drv_resp_data  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    #2 rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    vectors++; if ({req_ready, resp_valid} !== 6'b0) begin miscompares++; $display("FAIL reset_ready_resp: got %b required 0", {req_ready, resp_valid}); end
    vectors++; if (resp_data !== '0) begin miscompares++; $display("FAIL reset_resp_data: got %h required 0", resp_data); end
    vectors++; if ({drv_req_valid, drv_req_is_write, drv_req_addr, drv_req_wdata, drv_req_wstrb} !== '0) begin miscompares++; $display("FAIL reset_drv_req: got %b/%b/%h/%h/%h required 0", drv_req_valid, drv_req_is_write, drv_req_addr, drv_req_wdata, drv_req_wstrb); end
    vectors++; if ({busy, grant_id, timeout, spurious_resp} !== 5'b0) begin miscompares++; $display("FAIL reset_status: got %b required 0", {busy, grant_id, timeout, spurious_resp}); end
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    req_valid = 3'b010;
    req_addr[1*AW +: AW] = 32'h0000_1000;
    @(negedge clk);
    vectors++; if (req_ready !== 3'b010) begin miscompares++; $display("FAIL read_ready: got %b required 010", req_ready); end
    tick();
    req_valid = '0;
    drv_req_ready = 1'b1;
    @(negedge clk);
    vectors++; if ({drv_req_valid, drv_req_is_write, drv_req_addr} !== {1'b1, 1'b0, 32'h0000_1000}) begin miscompares++; $display("FAIL read_issue: got v=%b w=%b a=%h required v=1 w=0 a=00001000", drv_req_valid, drv_req_is_write, drv_req_addr); end
    vectors++; if ({busy, grant_id} !== 3'b101) begin miscompares++; $display("FAIL read_grant: got busy=%b id=%0d required busy=1 id=1", busy, grant_id); end
    tick();
    drv_req_ready  = 1'b0;
    drv_resp_valid = 1'b1;
    drv_resp_data  = 64'hDEAD_BEEF_CAFE_F00D;
    @(negedge clk);
    vectors++; if ({drv_req_valid, resp_valid} !== 4'b0) begin miscompares++; $display("FAIL read_wait: got drv_v=%b resp_v=%b required 0", drv_req_valid, resp_valid); end
    tick();
    drv_resp_valid = 1'b0;
    @(negedge clk);
    vectors++; if (resp_valid !== 3'b010) begin miscompares++; $display("FAIL read_resp_valid: got %b required 010", resp_valid); end
    vectors++; if (resp_data !== 64'hDEAD_BEEF_CAFE_F00D) begin miscompares++; $display("FAIL read_resp_data: got %h required deadbeefcafef00d", resp_data); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL read_idle: got busy=%b required 0", busy); end
    tick();
    @(negedge clk);
    vectors++; if (resp_valid !== 3'b000) begin miscompares++; $display("FAIL read_pulse_width: got %b required 000", resp_valid); end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp_oh;
    logic [DW-1:0] exp_data;
    int prev;
    do_reset();
    for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = 32'h0000_0100 * (i + 1);
    req_valid = 3'b111;
    prev = 0;
    exp_data = '0;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      exp_oh = 3'b001 << (k % 3);
      vectors++; if (req_ready !== exp_oh) begin miscompares++; $display("FAIL rr_ready[%0d]: got %b required %b", k, req_ready, exp_oh); end
      if (k > 0) begin
        vectors++; if ({resp_valid, resp_data} !== {3'b001 << prev, exp_data}) begin miscompares++; $display("FAIL rr_resp[%0d]: got %b/%h required %b/%h", k - 1, resp_valid, resp_data, 3'b001 << prev, exp_data); end
      end
      tick();
      drv_req_ready = 1'b1;
      @(negedge clk);
      vectors++; if ({grant_id, drv_req_addr} !== {2'(k % 3), 32'h0000_0100 * ((k % 3) + 1)}) begin miscompares++; $display("FAIL rr_grant[%0d]: got id=%0d a=%h required id=%0d", k, grant_id, drv_req_addr, k % 3); end
      tick();
      drv_req_ready  = 1'b0;
      drv_resp_valid = 1'b1;
      exp_data       = 64'hA5A5_0000_0000_0000 + 64'(k);
      drv_resp_data  = exp_data;
      prev           = k % 3;
      tick();
      drv_resp_valid = 1'b0;
      @(negedge clk);
    end
    vectors++; if ({resp_valid, resp_data} !== {3'b100, exp_data}) begin miscompares++; $display("FAIL rr_resp_last: got %b/%h required 100/%h", resp_valid, resp_data, exp_data); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_write_stall();
    logic [1+1+AW+DW+SW-1:0] exp_bus;
    req_valid = 3'b100;
    req_is_write = 3'b100;
    req_addr[2*AW +: AW]  = 32'h2000_0040;
    req_wdata[2*DW +: DW] = 64'h1122_3344_5566_7788;
    req_wstrb[2*SW +: SW] = 8'h0F;
    exp_bus = {1'b1, 1'b1, 32'h2000_0040, 64'h1122_3344_5566_7788, 8'h0F};
    @(negedge clk);
    vectors++; if (req_ready !== 3'b100) begin miscompares++; $display("FAIL wr_ready: got %b required 100", req_ready); end
    tick();
    req_valid = '0;
    req_addr[2*AW +: AW]  = 32'hFFFF_FFFF;
    req_wdata[2*DW +: DW] = '1;
    req_wstrb[2*SW +: SW] = 8'hF0;
    for (int c = 0; c < 6; c++) begin
      drv_req_ready = (c == 5);
      @(negedge clk);
      vectors++; if ({drv_req_valid, drv_req_is_write, drv_req_addr, drv_req_wdata, drv_req_wstrb} !== exp_bus) begin miscompares++; $display("FAIL wr_stable[%0d]: got v=%b w=%b a=%h d=%h s=%h", c, drv_req_valid, drv_req_is_write, drv_req_addr, drv_req_wdata, drv_req_wstrb); end
      tick();
    end
    drv_req_ready  = 1'b0;
    drv_resp_valid = 1'b1;
    drv_resp_data  = 64'hFFFF_0000_1234_5678;
    tick();
    drv_resp_valid = 1'b0;
    @(negedge clk);
    vectors++; if ({resp_valid, resp_data} !== {3'b100, 64'h0}) begin miscompares++; $display("FAIL wr_resp: got %b/%h required 100/0", resp_valid, resp_data); end
    req_valid = 3'b111;
    #1;
    vectors++; if (req_ready !== 3'b001) begin miscompares++; $display("FAIL wr_ptr_wrap: got %b required 001", req_ready); end
    req_valid = '0;
    req_is_write = '0;
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    @(negedge clk);
    vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL tmo_initial: got %b required 0", timeout); end
    req_valid = 3'b001;
    req_addr[0 +: AW] = 32'h0000_3000;
    tick();
    req_valid = '0;
    drv_req_ready = 1'b1;
    tick();
    drv_req_ready = 1'b0;
    for (int w = 1; w <= 20; w++) begin
      @(negedge clk);
      if (w == 4) begin
        vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL tmo_early: got %b required 0", timeout); end
      end
      tick();
    end
    @(negedge clk);
    vectors++; if ({timeout, busy} !== 2'b11) begin miscompares++; $display("FAIL tmo_set: got timeout=%b busy=%b required 1 1", timeout, busy); end
    drv_resp_valid = 1'b1;
    drv_resp_data  = 64'h0000_0000_0BAD_F00D;
    tick();
    drv_resp_valid = 1'b0;
    @(negedge clk);
    vectors++; if ({resp_valid, resp_data} !== {3'b001, 64'h0000_0000_0BAD_F00D}) begin miscompares++; $display("FAIL tmo_completes: got %b/%h required 001/0badf00d", resp_valid, resp_data); end
    tick();
    tick();
    @(negedge clk);
    vectors++; if (timeout !== 1'b1) begin miscompares++; $display("FAIL tmo_sticky: got %b required 1", timeout); end
  endtask

  task automatic test_spurious();
    @(negedge clk);
    vectors++; if (spurious_resp !== 1'b0) begin miscompares++; $display("FAIL spur_initial: got %b required 0", spurious_resp); end
    drv_resp_valid = 1'b1;
    drv_resp_data  = 64'h5555_5555_5555_5555;
    tick();
    drv_resp_valid = 1'b0;
    @(negedge clk);
    vectors++; if ({spurious_resp, resp_valid, busy} !== 5'b10000) begin miscompares++; $display("FAIL spur_flag: got spur=%b resp_v=%b busy=%b required 1 000 0", spurious_resp, resp_valid, busy); end
    tick();
    @(negedge clk);
    vectors++; if ({spurious_resp, resp_valid} !== 4'b1000) begin miscompares++; $display("FAIL spur_sticky: got spur=%b resp_v=%b required 1 000", spurious_resp, resp_valid); end
  endtask

  task automatic test_reset_mid();
    req_valid = 3'b010;
    req_addr[1*AW +: AW] = 32'h0000_4000;
    tick();
    req_valid = '0;
    drv_req_ready = 1'b1;
    tick();
    drv_req_ready = 1'b0;
    @(negedge clk);
    vectors++; if ({busy, grant_id} !== 3'b101) begin miscompares++; $display("FAIL mid_in_flight: got busy=%b id=%0d required 1 1", busy, grant_id); end
    rst_n = 1'b0;
    #1;
    vectors++; if ({busy, drv_req_valid, grant_id, timeout, spurious_resp, resp_valid, resp_data, drv_req_addr} !== '0) begin miscompares++; $display("FAIL mid_reset_outputs: got busy=%b drv_v=%b id=%0d tmo=%b spur=%b resp_v=%b rd=%h a=%h", busy, drv_req_valid, grant_id, timeout, spurious_resp, resp_valid, resp_data, drv_req_addr); end
    tick();
    rst_n = 1'b1;
    tick();
    req_valid = 3'b111;
    @(negedge clk);
    vectors++; if ({req_ready, resp_valid} !== {3'b001, 3'b000}) begin miscompares++; $display("FAIL mid_regrant: got ready=%b resp_v=%b required 001 000", req_ready, resp_valid); end
    req_valid = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_stall();
    test_timeout();
    test_spurious();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
